period_meter: RTL
=================

Name: period_meter

Overview:
- Parametrised successor to the single-period microsecond counter.
- Measures the time spanned by N consecutive periods of a slow external square-wave input. The result is whole microseconds plus a sub-microsecond clock remainder.
- Adds an input synchroniser, a programmable period count, timeout and abort.
- Sits between the raw low-frequency input pin and the auto-scaling/averaging logic, which divides the result by N.

Parameters:
- CLK_PER_US, 50, system clocks per microsecond (>=2).
- PRD_W, 20, width of the microsecond result.
- NCYC_W, 4, width of the period-count request.
- TIMEOUT_US, 1000000, abort threshold in microseconds; must be <= 2^PRD_W-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a measurement; accepted only while ready=1.
- abort  in  1  cancel the measurement in progress and return to IDLE without done_tick.
- si  in  1  asynchronous low-frequency input.
- n_cyc  in  NCYC_W  number of periods to span; sampled on the start cycle; 0 is treated as 1.
- ready  out  1  high only in IDLE.
- done_tick  out  1  one-clock pulse when prd/rem/tmo are updated.
- prd  out  PRD_W  whole microseconds elapsed across N periods.
- rem  out  $clog2(CLK_PER_US)  leftover clocks, range 0..CLK_PER_US-1.
- tmo  out  1  last measurement ended by timeout.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all state returns to IDLE; ready=1; done_tick=0; prd=0; rem=0; tmo=0; synchroniser flops cleared.
- Reset mid-measurement discards all progress immediately.
- Input synchroniser: si passes through a 2-flop synchroniser plus one delay flop. edg = sync & ~dly.
  - edg is a single-clock tick, two clocks after si is first sampled high.
  - Falling edges are ignored.
- States: IDLE, ARM, COUNT, DONE.
- IDLE:
  - ready=1.
  - start=1: latch n_lat = max(n_cyc,1), clear prescaler t and microsecond counter p, go to ARM.
- ARM:
  - t/p run as a timeout timer.
  - On edg: t=1 (the edge cycle is counted), p=0, edge counter e=0, go to COUNT.
- COUNT:
  - Every cycle: t increments; when t wraps from CLK_PER_US-1 to 0, p increments.
  - On edg: e increments; when e+1 == n_lat, go to DONE and latch results.
    - The closing-edge cycle is not counted.
  - Result definition: E = clocks from the opening edg tick to the closing edg tick. prd = floor(E/CLK_PER_US), rem = E mod CLK_PER_US.
- DONE:
  - done_tick=1 for exactly one clock; then go to IDLE.
  - Outputs become valid on the same cycle as done_tick and are held until the next done_tick or reset.
- Timeout (ARM or COUNT): when p would reach TIMEOUT_US, go to DONE with tmo=1, prd=0, rem=0.
- abort=1 in ARM/COUNT: go to IDLE next clock. No done_tick; outputs keep their previous values. abort in IDLE/DONE is ignored.
- Simultaneous events:
  - abort beats edg and timeout.
  - Closing edg beats timeout (valid result, tmo=0).
  - start while ready=0 is ignored.
  - start and abort together in IDLE: start wins.
- Latency:
  - done_tick asserts 1 clock after the closing edg tick, which is 3 clocks after si is sampled high.
  - ready returns 1 clock after done_tick.
- Width rules:
  - t counter: $clog2(CLK_PER_US) bits.
  - p counter: PRD_W bits; cannot overflow, guaranteed by the TIMEOUT_US constraint.
  - e counter: NCYC_W bits.

Decomposition:
- Shared package period_meter_pkg holds:
  - state enum (IDLE, ARM, COUNT, DONE);
  - function computing the rem width;
  - default CLK_PER_US constant.
- One natural sub-module: edge_sync, the 2-flop synchroniser plus rising-edge tick, with async reset. It is reusable by other LF-input blocks.

Test Plan:
- Single period (CLK_PER_US=50): si period 500 clk, n_cyc=1, start → done_tick, prd=10, rem=0, tmo=0; ready low throughout the measurement.
- Multi-period and n_cyc=0: period 525 clk, n_cyc=4 → prd=42, rem=0; n_cyc=0 → prd=10, rem=25.
- Timeout (TIMEOUT_US=100): si held low after start → done_tick about 100 µs later with tmo=1, prd=0. Next valid measurement clears tmo.
- Abort: assert abort mid-COUNT → ready=1 next clock, no done_tick, prd/rem unchanged from the previous result. start during COUNT has no effect.
- Async reset: assert reset mid-COUNT between clock edges → outputs zero immediately; after release, a fresh measurement of 500 clk gives prd=10.
- Glitch/priority: closing edge on the same cycle as the timeout threshold → valid prd, tmo=0. abort on the same cycle as the closing edge → no done_tick.

Source files
------------

// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared state encoding, defaults and width helper for period_meter
package period_meter_pkg;

  localparam int DEF_CLK_PER_US = 50;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARM   = 2'd1;
  localparam state_t ST_COUNT = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic int rem_width(input int clk_per_us);
    return (clk_per_us < 2) ? 1 : $clog2(clk_per_us);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - 2-flop synchroniser plus delay flop giving a one-clock rising-edge tick
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic edg
);

  logic [1:0] sync;
  logic       dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      dly  <= sync[1];
    end
  end

  assign edg = sync[1] & ~dly;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures N periods of a slow input in whole microseconds plus clock remainder
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CLK_PER_US = DEF_CLK_PER_US,
  parameter int PRD_W      = 20,
  parameter int NCYC_W     = 4,
  parameter int TIMEOUT_US = 1000000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 si,
  input  logic [NCYC_W-1:0]                    n_cyc,
  output logic                                 ready,
  output logic                                 done_tick,
  output logic [PRD_W-1:0]                     prd,
  output logic [rem_width(CLK_PER_US)-1:0]     rem,
  output logic                                 tmo
);

  localparam int REM_W = rem_width(CLK_PER_US);
  localparam logic [REM_W-1:0] T_MAX  = REM_W'(CLK_PER_US - 1);
  localparam logic [PRD_W-1:0] P_LAST = PRD_W'(TIMEOUT_US - 1);

  state_t            state;
  logic              edg;
  logic [REM_W-1:0]  t, t_nxt;
  logic [PRD_W-1:0]  p, p_nxt;
  logic [NCYC_W-1:0] e, n_lat;
  logic              t_wrap, tmo_hit, close_hit;

  edge_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (si),
    .edg   (edg)
  );

  // t/p form one mixed-radix counter: t is the sub-microsecond digit
  assign t_wrap    = (t == T_MAX);
  assign t_nxt     = t_wrap ? '0 : t + REM_W'(1);
  assign p_nxt     = t_wrap ? p + PRD_W'(1) : p;
  assign tmo_hit   = t_wrap && (p == P_LAST);
  assign close_hit = ({1'b0, e} + (NCYC_W + 1)'(1)) == {1'b0, n_lat};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      t     <= '0;
      p     <= '0;
      e     <= '0;
      n_lat <= '0;
      prd   <= '0;
      rem   <= '0;
      tmo   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_lat <= (n_cyc == '0) ? NCYC_W'(1) : n_cyc;
            t     <= '0;
            p     <= '0;
            state <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (edg) begin
            // the opening-edge cycle itself is the first counted clock
            t     <= REM_W'(1);
            p     <= '0;
            e     <= '0;
            state <= ST_COUNT;
          end else if (tmo_hit) begin
            prd   <= '0;
            rem   <= '0;
            tmo   <= 1'b1;
            state <= ST_DONE;
          end else begin
            t <= t_nxt;
            p <= p_nxt;
          end
        end
        ST_COUNT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (edg && close_hit) begin
            prd   <= p;
            rem   <= t;
            tmo   <= 1'b0;
            state <= ST_DONE;
          end else if (tmo_hit) begin
            prd   <= '0;
            rem   <= '0;
            tmo   <= 1'b1;
            state <= ST_DONE;
          end else begin
            t <= t_nxt;
            p <= p_nxt;
            if (edg) e <= e + NCYC_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready     = (state == ST_IDLE);
  assign done_tick = (state == ST_DONE);

endmodule
